muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have clk_i  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have rst_i  input  1  asynchronous, active-high reset.
REQ-003 SHALL have start_i  input  1  EX-stage request; sampled only in IDLE.
REQ-004 SHALL have funct3_i  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have rs1_data_i  input  32  forwarded operand A, i.e. after the forwarding mux.
REQ-006 SHALL have rs2_data_i  input  32  forwarded operand B, i.e. after the forwarding mux.
REQ-007 SHALL have rd_addr_i  input  5  destination register tag.
REQ-008 SHALL have flush_i  input  1  synchronous abort of any in-flight op.
REQ-009 SHALL have stall_o  output  1  freeze IF/ID/EX pipeline registers.
REQ-010 SHALL have busy_o  output  1  state != IDLE.
REQ-011 SHALL have done_o  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have result_o  output  32  op result, held until next accepted start.
REQ-013 SHALL have rd_addr_o  output  5  tag captured at start, held with result_o.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-015 SHALL, in IDLE with start_i=1, latch operands, funct3_i and rd_addr_i, then go to MUL if funct3_i[2]=0, else to DIV.
REQ-016 SHALL, in IDLE with start_i=1 and divisor=0 or signed overflow (DIV/REM, A=0x8000_0000, B=0xFFFF_FFFF), go to FIX with the special result preloaded.
REQ-017 SHALL compute the 33x33 signed/unsigned product in MUL, register it, then go to FIX: MUL=low 32 bits, MULH/MULHSU/MULHU=high 32 bits, sign extension per operand per funct3.
REQ-018 SHALL run restoring division on absolute values for exactly 32 DIV cycles (one quotient bit per cycle, 6-bit iteration counter), then go to FIX.
REQ-019 SHALL, in FIX, apply signs: quotient negated iff signed op and signs differ; remainder takes dividend sign; then go to DONE.
REQ-020 SHALL, on divide by zero, produce quotient 0xFFFF_FFFF and remainder = dividend, for both signed and unsigned ops.
REQ-021 SHALL, on signed overflow, produce quotient 0x8000_0000 and remainder 0.
REQ-022 SHALL assert done_o only in DONE, for exactly one cycle, then return to IDLE.
REQ-023 SHALL give latency from start edge to done_o: MUL* = 3 cycles (IDLE->MUL->FIX->DONE); DIV* = 34 cycles; special-case div = 2 cycles.
REQ-024 SHALL drive stall_o = (IDLE & start_i) | MUL | DIV | FIX, and deassert it in DONE so the pipeline advances with the result.
REQ-025 SHALL ignore start_i outside IDLE, including in DONE.
REQ-026 SHALL, on flush_i=1, go to IDLE next edge without asserting done_o; flush_i has priority over start_i and leaves result_o unchanged.
REQ-027 SHALL keep rs1/rs2 data changes after acceptance without effect on the result.

Reset
REQ-028 SHALL, on rst_i=1, asynchronously force state=IDLE, result_o=0, rd_addr_o=0, done_o=0, busy_o=0, and the counter to 0.
REQ-029 SHALL abort an op in progress when rst_i is asserted mid-operation, with no done_o after release.
REQ-030 SHALL drive stall_o=0 while rst_i=1.

Structure
REQ-031 SHALL keep funct3 encodings, the state enum and XLEN=32 in shared package muldiv_pkg.
REQ-032 SHALL place one division iteration (shift, trial subtract, quotient bit) in sub-module muldiv_div_step.
REQ-033 SHALL register result_o and rd_addr_o, with no combinational path from inputs to them.

Verification
REQ-034 SHALL cover: MUL 0xFFFF_FFFF x 2 -> done_o 3 cycles after start, result 0xFFFF_FFFE; MULHU same operands -> 0x0000_0001; MULH -> 0xFFFF_FFFF.
REQ-035 SHALL cover: DIV -7/2 -> 0xFFFF_FFFD after 34 cycles; REM -7/2 -> 0xFFFF_FFFF; stall_o high exactly 34 cycles including the start cycle.
REQ-036 SHALL cover: DIVU 5/0 -> 0xFFFF_FFFF and REMU 5/0 -> 5, done_o 2 cycles after start; DIV 0x8000_0000/-1 -> 0x8000_0000, REM -> 0.
REQ-037 SHALL cover: flush_i at DIV cycle 10 -> IDLE next cycle, no done_o, result_o unchanged; new start accepted the following cycle.
REQ-038 SHALL cover: rst_i pulse mid-DIV -> all outputs 0 immediately; start_i held high during busy and DONE -> no second op accepted.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: XLEN, funct3 opcodes
// and the sequencer state encoding.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    // DIV and REM treat their operands as two's complement; DIVU/REMU do not.
    function automatic logic div_is_signed(input logic [2:0] f3);
        return ~f3[0];
    endfunction

    // Operand A is signed for MULH and MULHSU, operand B only for MULH.
    function automatic logic mul_a_signed(input logic [2:0] f3);
        return (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10);
    endfunction

    function automatic logic mul_b_signed(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, emit one quotient bit.
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] rem_shift;
    logic [XLEN:0] trial;

    // quo_i doubles as the dividend shift register: its MSB feeds the remainder
    // while the new quotient bit enters at the LSB.
    assign rem_shift = {rem_i, quo_i[XLEN-1]};
    assign trial     = rem_shift - {1'b0, dvs_i};
    assign rem_o     = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_o     = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage: single-cycle 33x33 multiply,
// 32-cycle restoring divide, sign fix-up, and a one-cycle done pulse.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    state_e          state_q;
    logic [5:0]      cnt_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_addr_q;

    logic [2:0]      f3_q;
    logic [4:0]      tag_q;
    logic [XLEN-1:0] opa_q;
    logic [XLEN-1:0] opb_q;
    logic [XLEN-1:0] rem_q;
    logic [63:0]     prod_q;
    logic            qneg_q;
    logic            rneg_q;
    logic            special_q;
    logic [XLEN-1:0] spec_q;

    logic            accept;
    logic            in_div;
    logic            in_sgn;
    logic            div_zero;
    logic            div_ovf;
    logic            in_special;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] spec_d;

    assign accept     = (state_q == ST_IDLE) && start_i && !flush_i;
    assign in_div     = funct3_i[2];
    assign in_sgn     = div_is_signed(funct3_i);
    assign div_zero   = (rs2_data_i == '0);
    assign div_ovf    = in_sgn && (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
    assign in_special = in_div && (div_zero || div_ovf);
    assign a_neg      = in_sgn && rs1_data_i[XLEN-1];
    assign b_neg      = in_sgn && rs2_data_i[XLEN-1];
    assign abs_a      = a_neg ? (~rs1_data_i + 32'd1) : rs1_data_i;
    assign abs_b      = b_neg ? (~rs2_data_i + 32'd1) : rs2_data_i;

    // Divide-by-zero and overflow results bypass the iterative divider.
    always_comb begin
        spec_d = 32'h8000_0000;
        if (div_zero)
            spec_d = funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
        else if (funct3_i[1])
            spec_d = '0;
    end

    logic [63:0] mul_a_w;
    logic [63:0] mul_b_w;
    logic [63:0] prod_d;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product then
    // equal the true 33x33 product for every operand signedness.
    assign mul_a_w = {{32{mul_a_signed(f3_q) & opa_q[XLEN-1]}}, opa_q};
    assign mul_b_w = {{32{mul_b_signed(f3_q) & opb_q[XLEN-1]}}, opb_q};
    assign prod_d  = mul_a_w * mul_b_w;

    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;

    muldiv_div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (opa_q),
        .dvs_i (opb_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] res_fix;

    assign q_fix = qneg_q ? (~opa_q + 32'd1) : opa_q;
    assign r_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;

    always_comb begin
        res_fix = q_fix;
        if (special_q)
            res_fix = spec_q;
        else if (!f3_q[2])
            res_fix = (f3_q[1:0] == 2'b00) ? prod_q[31:0] : prod_q[63:32];
        else if (f3_q[1])
            res_fix = r_fix;
    end

    // Operand/datapath registers carry no reset; they are always loaded at accept.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            f3_q      <= funct3_i;
            tag_q     <= rd_addr_i;
            opa_q     <= in_div ? abs_a : rs1_data_i;
            opb_q     <= in_div ? abs_b : rs2_data_i;
            rem_q     <= '0;
            qneg_q    <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
            special_q <= in_special;
            spec_q    <= spec_d;
        end else if (state_q == ST_MUL) begin
            prod_q <= prod_d;
        end else if (state_q == ST_DIV) begin
            rem_q <= rem_d;
            opa_q <= quo_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            cnt_q <= '0;
                            if (in_special)
                                state_q <= ST_FIX;
                            else if (in_div)
                                state_q <= ST_DIV;
                            else
                                state_q <= ST_MUL;
                        end
                    end
                    ST_MUL: state_q <= ST_FIX;
                    ST_DIV: begin
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31)
                            state_q <= ST_FIX;
                    end
                    ST_FIX: begin
                        result_q  <= res_fix;
                        rd_addr_q <= tag_q;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign rd_addr_o = rd_addr_q;
    assign stall_o   = !rst_i && (((state_q == ST_IDLE) && start_i) || (state_q == ST_MUL)
                                  || (state_q == ST_DIV) || (state_q == ST_FIX));

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic
// reference model of the RV32M multiply/divide operations.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int tests = 0;
    int fails = 0;

    muldiv_unit dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .funct3_i   (f3),
        .rs1_data_i (a),
        .rs2_data_i (b),
        .rd_addr_i  (rd),
        .flush_i    (flush),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_addr_o  (rd_addr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     p;
        int              ix;
        int              iy;
        logic            ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'(x);
        uy  = longint'(y);
        ix  = int'(x);
        iy  = int'(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ux * uy;           return p[31:0];  end
            3'd1: begin p = sx * sy;           return p[63:32]; end
            3'd2: begin p = sx * longint'(uy); return p[63:32]; end
            3'd3: begin p = ux * uy;           return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ix / iy);
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ovf ? 32'd0 : 32'(ix % iy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2])
            return 3;
        if (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))
            return 2;
        return 34;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] tag, input bit hold);
        int          lat;
        int          stalls;
        logic [31:0] exp;
        lat    = 99;
        stalls = 0;
        exp    = ref_op(f, x, y);
        start  = 1'b1;
        f3     = f;
        a      = x;
        b      = y;
        rd     = tag;
        #1;
        if (stall_o) stalls++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!hold) start = 1'b0;
                a  = $urandom;
                b  = $urandom;
                f3 = 3'($urandom);
                rd = 5'($urandom);
            end
            if (stall_o) stalls++;
            if (done_o) begin
                lat = c;
                break;
            end
        end
        check($sformatf("latency f3=%0d a=%h b=%h", f, x, y), 32'(lat), 32'(ref_lat(f, x, y)));
        check($sformatf("result f3=%0d a=%h b=%h", f, x, y), result_o, exp);
        check("rd_addr", 32'(rd_addr_o), 32'(tag));
        check($sformatf("stall cycles f3=%0d", f), 32'(stalls), 32'(ref_lat(f, x, y)));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done single pulse", 32'(done_o), 32'd0);
        check("idle after done", 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        int          dcount;

        rst   = 1'b1;
        start = 1'b1;
        flush = 1'b0;
        f3    = 3'd0;
        a     = '0;
        b     = '0;
        rd    = '0;
        #1;
        check("reset result", result_o, 32'd0);
        check("reset rd_addr", 32'(rd_addr_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset stall", 32'(stall_o), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd1, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd2, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
        run_op(3'd5, 32'd5, 32'd0, 5'd7, 1'b0);
        run_op(3'd7, 32'd5, 32'd0, 5'd8, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd11, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd12, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 5'd13, 1'b1);

        // Flush in the tenth divide cycle.
        prev  = result_o;
        start = 1'b1;
        f3    = 3'd4;
        a     = 32'd1000;
        b     = 32'd3;
        rd    = 5'd20;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 32'(busy_o), 32'd0);
        check("flush done", 32'(done_o), 32'd0);
        check("flush result held", result_o, prev);
        run_op(3'd0, 32'd3, 32'd4, 5'd21, 1'b0);

        // Reset pulse in the middle of a divide.
        start = 1'b1;
        f3    = 3'd5;
        a     = 32'd12345;
        b     = 32'd7;
        rd    = 5'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midop reset result", result_o, 32'd0);
        check("midop reset rd_addr", 32'(rd_addr_o), 32'd0);
        check("midop reset busy", 32'(busy_o), 32'd0);
        check("midop reset done", 32'(done_o), 32'd0);
        check("midop reset stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) dcount++;
        end
        check("no done after reset", 32'(dcount), 32'd0);

        for (int i = 0; i < 60; i++) begin
            rf  = 3'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) rb = -32'($urandom_range(1, 15));
            run_op(rf, ra, rb, 5'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
